// File: rtl/rca_ou_lsq_pkg.sv
// Shared types and constants for the operator-unit load/store queue.
package rca_lsq_types;

    localparam int XLEN = 32;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        logic [2:0]      fn3;
        logic            is_load;
    } lsq_entry_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } lsq_state_t;

endpackage

// File: rtl/rca_ou_lsq_if.sv
// Request and memory-port signals between an operator unit, the LSQ and memory.
interface rca_ou_lsq_if
    import rca_lsq_types::*;
;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [2:0]      fn3;
    logic            load;
    logic            store;
    logic            new_request;
    logic            lsq_full;
    logic [XLEN-1:0] load_data;
    logic            load_complete;
    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic            mem_we;
    logic [3:0]      mem_be;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_ack;
    logic [XLEN-1:0] mem_rdata;

    // The LSQ side.
    modport slave (
        input  addr, data, fn3, load, store, new_request, mem_ack, mem_rdata,
        output lsq_full, load_data, load_complete,
               mem_req, mem_addr, mem_we, mem_be, mem_wdata
    );

    // Requesting unit plus memory, seen from outside the LSQ.
    modport master (
        output addr, data, fn3, load, store, new_request, mem_ack, mem_rdata,
        input  lsq_full, load_data, load_complete,
               mem_req, mem_addr, mem_we, mem_be, mem_wdata
    );

endinterface

// File: rtl/rca_ou_lsq_align.sv
// Byte-lane formatting: store enables/replication and load extraction with sign/zero extension.
module rca_lsq_align
    import rca_lsq_types::*;
(
    input  logic [2:0]      fn3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] data,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        be    = 4'hF;
        wdata = data;
        case (fn3)
            LS_B: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{data[7:0]}};
            end
            LS_H: begin
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        lane_byte = rdata[7:0];
        case (addr_lo)
            2'd1:    lane_byte = rdata[15:8];
            2'd2:    lane_byte = rdata[23:16];
            2'd3:    lane_byte = rdata[31:24];
            default: lane_byte = rdata[7:0];
        endcase
    end

    // Misaligned halves are not trapped; only addr[1] picks the half.
    assign lane_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        load_data = rdata;
        case (fn3)
            LS_B:    load_data = {{(XLEN-8){lane_byte[7]}}, lane_byte};
            LS_BU:   load_data = {{(XLEN-8){1'b0}}, lane_byte};
            LS_H:    load_data = {{(XLEN-16){lane_half[15]}}, lane_half};
            LS_HU:   load_data = {{(XLEN-16){1'b0}}, lane_half};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/rca_ou_lsq.sv
// In-order load/store queue: buffers operator-unit requests and issues them one per cycle to memory.
//   state | meaning
//   IDLE  | queue empty or just filled; no memory request
//   ISSUE | head entry presented on the memory port until acked
module rca_ou_lsq
    import rca_lsq_types::*;
#(
    parameter int LSQ_DEPTH = 4
) (
    input logic         clk,
    input logic         rst,
    rca_ou_lsq_if.slave bus
);

    localparam int PTR_W = $clog2(LSQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(LSQ_DEPTH);

    lsq_entry_t       queue [LSQ_DEPTH];
    lsq_entry_t       head_entry;
    lsq_entry_t       new_entry;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    lsq_state_t       state;
    lsq_state_t       state_next;
    logic             full;
    logic             enq;
    logic             deq;
    logic [3:0]       fmt_be;
    logic [XLEN-1:0]  fmt_wdata;
    logic [XLEN-1:0]  fmt_load;
    logic [XLEN-1:0]  load_data_q;
    logic             load_complete_q;

    // Full is judged on the registered count, so a same-cycle dequeue does not open a slot.
    assign full = (count == DEPTH_CNT);
    assign enq  = bus.new_request && !full && (bus.load || bus.store);
    assign deq  = (state == ISSUE) && bus.mem_ack;

    assign new_entry  = '{addr: bus.addr, data: bus.data, fn3: bus.fn3, is_load: bus.load};
    assign head_entry = queue[head];
    assign count_next = count + CNT_W'(enq) - CNT_W'(deq);

    always_ff @(posedge clk) begin
        if (enq) begin
            queue[tail] <= new_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            state <= IDLE;
        end else begin
            if (enq) tail <= tail + PTR_W'(1);
            if (deq) head <= head + PTR_W'(1);
            count <= count_next;
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (count != '0) state_next = ISSUE;
            ISSUE:   if (deq && count_next == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    rca_lsq_align u_align (
        .fn3       (head_entry.fn3),
        .addr_lo   (head_entry.addr[1:0]),
        .data      (head_entry.data),
        .rdata     (bus.mem_rdata),
        .be        (fmt_be),
        .wdata     (fmt_wdata),
        .load_data (fmt_load)
    );

    // Reset takes priority so an ack arriving in the reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_complete_q <= 1'b0;
            load_data_q     <= '0;
        end else begin
            load_complete_q <= deq && head_entry.is_load;
            if (deq && head_entry.is_load) begin
                load_data_q <= fmt_load;
            end
        end
    end

    assign bus.lsq_full      = full;
    assign bus.load_complete = load_complete_q;
    assign bus.load_data     = load_data_q;
    assign bus.mem_req       = (state == ISSUE);
    assign bus.mem_addr      = {head_entry.addr[XLEN-1:2], 2'b00};
    assign bus.mem_we        = !head_entry.is_load;
    assign bus.mem_be        = head_entry.is_load ? 4'hF : fmt_be;
    assign bus.mem_wdata     = fmt_wdata;

endmodule

// File: tb/tb_rca_ou_lsq.sv
// Directed bench for rca_ou_lsq: single-access vector table plus fill, streaming, reset and malformed sequences.
module tb_rca_ou_lsq;
    import rca_lsq_types::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    logic        stream_mode = 1'b0;
    logic [31:0] rdata_fix = '0;

    rca_ou_lsq_if bus ();

    rca_ou_lsq #(.LSQ_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Memory model for streaming: read word derived from the word address.
    assign bus.mem_rdata = stream_mode ? (bus.mem_addr ^ 32'h5A5A_0000) : rdata_fix;

    typedef struct {
        string       name;
        logic [2:0]  fn3;
        logic [31:0] addr;
        logic [31:0] data;
        logic        load;
        logic        store;
        logic [31:0] rdata;
        logic [31:0] e_addr;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_ld;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.new_request = 1'b0;
        bus.load        = 1'b0;
        bus.store       = 1'b0;
        bus.fn3         = 3'b000;
        bus.addr        = '0;
        bus.data        = '0;
    endtask

    task automatic drive_req(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                             input logic ld, input logic st);
        bus.new_request = 1'b1;
        bus.fn3         = f;
        bus.addr        = a;
        bus.data        = d;
        bus.load        = ld;
        bus.store       = st;
    endtask

    task automatic run_vec(input vec_t v);
        int k;
        bus.mem_ack = 1'b1;
        rdata_fix   = v.rdata;
        drive_req(v.fn3, v.addr, v.data, v.load, v.store);
        @(negedge clk);
        idle_inputs();
        k = 0;
        while (!bus.mem_req && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk({v.name, "_latency"}, 32'(k), 32'd1);
        chk({v.name, "_addr"}, bus.mem_addr, v.e_addr);
        chk({v.name, "_we"}, 32'(bus.mem_we), 32'(v.e_we));
        chk({v.name, "_be"}, 32'(bus.mem_be), 32'(v.e_be));
        if (v.e_we) chk({v.name, "_wdata"}, bus.mem_wdata, v.e_wdata);
        @(negedge clk);
        chk({v.name, "_complete"}, 32'(bus.load_complete), 32'(!v.e_we));
        if (!v.e_we) chk({v.name, "_ldata"}, bus.load_data, v.e_ld);
        @(negedge clk);
        chk({v.name, "_pulse_end"}, 32'(bus.load_complete), 32'd0);
        chk({v.name, "_idle"}, 32'(bus.mem_req), 32'd0);
    endtask

    initial begin
        bus.mem_ack = 1'b0;
        idle_inputs();

        //           name      fn3    addr          data          ld    st    rdata         e_addr        we    be       e_wdata       e_ld
        vecs[0]  = '{"sb",     LS_B,  32'h0000_1003, 32'h0000_00AB, 1'b0, 1'b1, 32'h0,        32'h0000_1000, 1'b1, 4'b1000, 32'hABAB_ABAB, 32'h0};
        vecs[1]  = '{"lbu",    LS_BU, 32'h0000_1003, 32'h0,        1'b1, 1'b0, 32'hAB00_0000, 32'h0000_1000, 1'b0, 4'hF,    32'h0,        32'h0000_00AB};
        vecs[2]  = '{"lb",     LS_B,  32'h0000_2001, 32'h0,        1'b1, 1'b0, 32'h0000_8000, 32'h0000_2000, 1'b0, 4'hF,    32'h0,        32'hFFFF_FF80};
        vecs[3]  = '{"lh",     LS_H,  32'h0000_2002, 32'h0,        1'b1, 1'b0, 32'h8001_0000, 32'h0000_2000, 1'b0, 4'hF,    32'h0,        32'hFFFF_8001};
        vecs[4]  = '{"lhu",    LS_HU, 32'h0000_2002, 32'h0,        1'b1, 1'b0, 32'h8001_0000, 32'h0000_2000, 1'b0, 4'hF,    32'h0,        32'h0000_8001};
        vecs[5]  = '{"sh_hi",  LS_H,  32'h0000_3002, 32'h1234_5678, 1'b0, 1'b1, 32'h0,        32'h0000_3000, 1'b1, 4'b1100, 32'h5678_5678, 32'h0};
        vecs[6]  = '{"sh_lo",  LS_H,  32'h0000_3000, 32'h1234_5678, 1'b0, 1'b1, 32'h0,        32'h0000_3000, 1'b1, 4'b0011, 32'h5678_5678, 32'h0};
        vecs[7]  = '{"sw",     LS_W,  32'h0000_4004, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0,        32'h0000_4004, 1'b1, 4'hF,    32'hDEAD_BEEF, 32'h0};
        vecs[8]  = '{"lw",     LS_W,  32'h0000_5000, 32'h0,        1'b1, 1'b0, 32'hCAFE_F00D, 32'h0000_5000, 1'b0, 4'hF,    32'h0,        32'hCAFE_F00D};
        vecs[9]  = '{"ldst",   LS_W,  32'h0000_6000, 32'h5555_5555, 1'b1, 1'b1, 32'h1234_5678, 32'h0000_6000, 1'b0, 4'hF,    32'h0,        32'h1234_5678};
        vecs[10] = '{"lbu_ff", LS_BU, 32'h0000_7000, 32'h0,        1'b1, 1'b0, 32'h0000_00FF, 32'h0000_7000, 1'b0, 4'hF,    32'h0,        32'h0000_00FF};
        vecs[11] = '{"lb_ff",  LS_B,  32'h0000_7000, 32'h0,        1'b1, 1'b0, 32'h0000_00FF, 32'h0000_7000, 1'b0, 4'hF,    32'h0,        32'hFFFF_FFFF};
        vecs[12] = '{"s_odd",  3'b011, 32'h0000_8001, 32'h1122_3344, 1'b0, 1'b1, 32'h0,        32'h0000_8000, 1'b1, 4'hF,    32'h1122_3344, 32'h0};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_full", 32'(bus.lsq_full), 32'd0);
        chk("rst_complete", 32'(bus.load_complete), 32'd0);
        chk("rst_ldata", bus.load_data, 32'd0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Malformed: neither load nor store must not enqueue.
        bus.mem_ack = 1'b1;
        drive_req(LS_W, 32'h0000_9000, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        idle_inputs();
        for (int c = 0; c < 4; c++) begin
            chk("drop_none_req", 32'(bus.mem_req), 32'd0);
            @(negedge clk);
        end

        // Fill and backpressure with memory stalled.
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) chk("fill_not_full_3", 32'(bus.lsq_full), 32'd0);
            if (i == 4) chk("fill_full_4", 32'(bus.lsq_full), 32'd1);
            drive_req(LS_W, 32'h10 * (i + 1), 32'h1111_1111 * (i + 1), 1'b0, 1'b1);
            @(negedge clk);
        end
        idle_inputs();
        @(negedge clk);
        chk("fill_full_hold", 32'(bus.lsq_full), 32'd1);
        chk("fill_req_stall", 32'(bus.mem_req), 32'd1);
        chk("fill_addr_stall", bus.mem_addr, 32'h10);
        bus.mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_req", 32'(bus.mem_req), 32'd1);
            chk("drain_addr", bus.mem_addr, 32'h10 * (i + 1));
            chk("drain_wdata", bus.mem_wdata, 32'h1111_1111 * (i + 1));
            chk("drain_full", 32'(bus.lsq_full), (i == 0) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        for (int c = 0; c < 3; c++) begin
            chk("drain_fifth_dropped", 32'(bus.mem_req), 32'd0);
            @(negedge clk);
        end

        // Streaming LW loads with memory always acking.
        begin
            int acc = 0;
            int cmp = 0;
            bit seen = 0;
            stream_mode = 1'b1;
            for (int c = 0; c < 14; c++) begin
                if (bus.mem_req) begin
                    if (acc < 8) chk("stream_addr", bus.mem_addr, 32'h100 + 32'(4 * acc));
                    acc++;
                    seen = 1;
                end else if (seen && acc < 8) begin
                    chk("stream_gap", 32'(bus.mem_req), 32'd1);
                end
                if (bus.load_complete) begin
                    if (cmp < 8) chk("stream_ldata", bus.load_data, (32'h100 + 32'(4 * cmp)) ^ 32'h5A5A_0000);
                    cmp++;
                end
                if (c < 8) drive_req(LS_W, 32'h100 + 32'(4 * c), 32'h0, 1'b1, 1'b0);
                else idle_inputs();
                @(negedge clk);
            end
            chk("stream_accesses", 32'(acc), 32'd8);
            chk("stream_completes", 32'(cmp), 32'd8);
            stream_mode = 1'b0;
        end

        // Reset while an access is in flight with three entries queued.
        bus.mem_ack = 1'b0;
        rdata_fix   = 32'h7777_7777;
        for (int i = 0; i < 3; i++) begin
            drive_req(LS_W, 32'h200 + 32'(4 * i), 32'h0, 1'b1, 1'b0);
            @(negedge clk);
        end
        idle_inputs();
        chk("rst_pre_req", 32'(bus.mem_req), 32'd1);
        rst         = 1'b1;
        bus.mem_ack = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mid_full", 32'(bus.lsq_full), 32'd0);
        chk("rst_mid_complete", 32'(bus.load_complete), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_after_complete", 32'(bus.load_complete), 32'd0);
            chk("rst_after_req", 32'(bus.mem_req), 32'd0);
        end
        chk("rst_after_ldata", bus.load_data, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
